// File: rtl/aes_arkey_iter.sv
// ---------------------------------------------------------------------------
// aes_arkey_iter
//
// Iterative AddRoundKey engine. A state block and a round index are captured
// on an in_valid/in_ready handshake. The selected round key (NB words taken
// from the expanded key store) is then XORed into the state CPC columns per
// cycle. The result is offered on an out_valid/out_ready handshake. XOR is its
// own inverse, so the same engine serves encryption and decryption.
//
// Parameters:
//   NB   columns per state (4 for AES)
//   NR   number of rounds (10/12/14); KExp holds NB*(NR+1) words
//   CPC  columns XORed per cycle: 1, 2 or 4, and it must divide NB
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   input block presented
//   in_ready   engine idle and able to accept a block
//   in_round   round whose key is applied, 0..NR
//   State_in   input state bytes, column-major (byte 4*j+i = row i, col j)
//   KExp       expanded key words, stable from accept until output handshake
//   out_valid  result available
//   out_ready  consumer accepts the result
//   out_err    qualifies out_valid: round was out of range, state unmodified
//   State_out  result state bytes
//   busy       a block is being processed or waiting to be taken
// ---------------------------------------------------------------------------
module aes_arkey_iter #(
  parameter int NB  = 4,
  parameter int NR  = 10,
  parameter int CPC = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_round,
  input  logic [7:0]  State_in [0:4*NB-1],
  input  logic [31:0] KExp     [0:NB*(NR+1)-1],
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_err,
  output logic [7:0]  State_out [0:4*NB-1],
  output logic        busy
);

  localparam int KW = (NB * (NR + 1) > 1) ? $clog2(NB * (NR + 1)) : 1;
  localparam int CW = $clog2(NB + 1);
  localparam int SW = (4 * NB > 1) ? $clog2(4 * NB) : 1;

  localparam logic [3:0]    NR_L     = 4'(NR);
  localparam logic [CW-1:0] CPC_L    = CW'(CPC);
  localparam logic [CW-1:0] LAST_COL = CW'(NB - CPC);

  // Reject column-per-cycle settings that would leave a partial group.
  if (!((CPC == 1) || (CPC == 2) || (CPC == 4)) || ((NB % CPC) != 0)) begin : g_bad_cpc
    $error("aes_arkey_iter: CPC must be 1, 2 or 4 and divide NB");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        r_fsm;
  logic [7:0]    r_state [0:4*NB-1];
  logic [3:0]    r_round;
  logic [CW-1:0] r_col;
  logic          r_err;
  logic          r_outValid;

  logic [KW-1:0] w_base;
  logic [KW-1:0] w_keyIdx;
  logic [31:0]   w_keyWord;
  logic [SW-1:0] w_byteIdx;
  logic [7:0]    w_xorState [0:4*NB-1];

  // First key word of the selected round. Only meaningful for legal rounds;
  // an out-of-range round never enters BUSY, so its index is never consumed.
  assign w_base = KW'(r_round) * KW'(NB);

  // Next value of the state for the CPC columns handled this cycle. Row 0
  // of a column takes the most significant byte of its key word.
  always_comb begin
    w_xorState = r_state;
    w_keyIdx   = '0;
    w_keyWord  = '0;
    w_byteIdx  = '0;
    for (int k = 0; k < CPC; k++) begin
      w_keyIdx  = w_base + KW'(r_col) + KW'(k);
      w_keyWord = KExp[w_keyIdx];
      for (int i = 0; i < 4; i++) begin
        w_byteIdx             = SW'(4 * (int'(r_col) + k) + i);
        w_xorState[w_byteIdx] = r_state[w_byteIdx] ^ w_keyWord[8*(3-i) +: 8];
      end
    end
  end

  // Control FSM and datapath registers. An out-of-range round skips BUSY and
  // returns the captured block untouched with the error flag set. The column
  // counter is cleared on the last group so it never points past the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fsm      <= IDLE;
      r_round    <= '0;
      r_col      <= '0;
      r_err      <= 1'b0;
      r_outValid <= 1'b0;
      for (int b = 0; b < 4 * NB; b++) begin
        r_state[b] <= '0;
      end
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state <= State_in;
            r_round <= in_round;
            r_col   <= '0;
            r_err   <= (in_round > NR_L);
            if (in_round > NR_L) begin
              r_fsm      <= DONE;
              r_outValid <= 1'b1;
            end else begin
              r_fsm <= BUSY;
            end
          end
        end
        BUSY: begin
          r_state <= w_xorState;
          if (r_col == LAST_COL) begin
            r_col      <= '0;
            r_fsm      <= DONE;
            r_outValid <= 1'b1;
          end else begin
            r_col <= r_col + CPC_L;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_fsm      <= IDLE;
            r_outValid <= 1'b0;
            r_err      <= 1'b0;
          end
        end
        default: begin
          r_fsm      <= IDLE;
          r_outValid <= 1'b0;
          r_err      <= 1'b0;
        end
      endcase
    end
  end

  // in_ready is held low while reset is asserted so no block can slip in on
  // the reset edge; otherwise it simply tracks the IDLE state.
  assign in_ready  = (r_fsm == IDLE) && !reset;
  assign out_valid = r_outValid;
  assign out_err   = r_err;
  assign busy      = (r_fsm != IDLE);
  assign State_out = r_state;

endmodule

// File: tb/tb_aes_arkey_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_arkey_iter
//
// Three engines with CPC = 1, 2 and 4 share one input stream so that results
// and latencies can be compared against hand-computed vectors (FIPS-197
// Appendix B round 0, a last-round key, an out-of-range round, back-pressure,
// reset in the middle of a block and the XOR involution).
// ---------------------------------------------------------------------------
module tb_aes_arkey_iter;

  localparam int NB = 4;
  localparam int NR = 10;
  localparam int NW = NB * (NR + 1);

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_round;
  logic        out_ready;
  logic [7:0]  stateIn [0:4*NB-1];
  logic [31:0] kexp    [0:NW-1];

  logic        inReady1, outValid1, outErr1, busy1;
  logic        inReady2, outValid2, outErr2, busy2;
  logic        inReady4, outValid4, outErr4, busy4;
  logic [7:0]  stateOut1 [0:4*NB-1];
  logic [7:0]  stateOut2 [0:4*NB-1];
  logic [7:0]  stateOut4 [0:4*NB-1];
  logic [127:0] so1, so2, so4;

  int vectors;
  int miscompares;
  int lat1, lat2, lat4;

  aes_arkey_iter #(.NB(NB), .NR(NR), .CPC(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(inReady1),
    .in_round(in_round), .State_in(stateIn), .KExp(kexp),
    .out_valid(outValid1), .out_ready(out_ready), .out_err(outErr1),
    .State_out(stateOut1), .busy(busy1)
  );

  aes_arkey_iter #(.NB(NB), .NR(NR), .CPC(2)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(inReady2),
    .in_round(in_round), .State_in(stateIn), .KExp(kexp),
    .out_valid(outValid2), .out_ready(out_ready), .out_err(outErr2),
    .State_out(stateOut2), .busy(busy2)
  );

  aes_arkey_iter #(.NB(NB), .NR(NR), .CPC(4)) dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(inReady4),
    .in_round(in_round), .State_in(stateIn), .KExp(kexp),
    .out_valid(outValid4), .out_ready(out_ready), .out_err(outErr4),
    .State_out(stateOut4), .busy(busy4)
  );

  // Flatten each output state so a whole block compares as one 128-bit value
  // written in the same byte order as the FIPS-197 listings.
  for (genvar b = 0; b < 4 * NB; b++) begin : g_pack
    assign so1[127-8*b -: 8] = stateOut1[b];
    assign so2[127-8*b -: 8] = stateOut2[b];
    assign so4[127-8*b -: 8] = stateOut4[b];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic loadState(input logic [127:0] v);
    for (int b = 0; b < 4 * NB; b++) begin
      stateIn[b] = v[127-8*b -: 8];
    end
  endtask

  // Background key words carry their own index so a wrong word is visible.
  task automatic loadKeys();
    for (int w = 0; w < NW; w++) begin
      kexp[w] = 32'h5A00_0000 | 32'(w * 32'h0001_0203);
    end
    kexp[0]  = 32'h2b7e1516;
    kexp[1]  = 32'h28aed2a6;
    kexp[2]  = 32'habf71588;
    kexp[3]  = 32'h09cf4f3c;
    kexp[40] = 32'hd014f9a8;
    kexp[41] = 32'hc9ee2589;
    kexp[42] = 32'he13f0cc8;
    kexp[43] = 32'hb6630ca6;
  endtask

  // Present one block for a single accept edge; afterwards the bench sits in
  // the first cycle following the accept.
  task automatic applyStimulus(input logic [3:0] rnd);
    in_round = rnd;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Hold out_ready low and record, per engine, how many cycles after the
  // accept edge out_valid is first seen. -1 means it never came.
  task automatic waitResults();
    out_ready = 1'b0;
    lat1 = -1;
    lat2 = -1;
    lat4 = -1;
    for (int n = 1; n <= 30; n++) begin
      if (lat1 < 0 && outValid1) lat1 = n;
      if (lat2 < 0 && outValid2) lat2 = n;
      if (lat4 < 0 && outValid4) lat4 = n;
      if (lat1 >= 0 && lat2 >= 0 && lat4 >= 0) break;
      tick();
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (inReady1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0", inReady1);
    end
    vectors++;
    if ({outValid1, outValid2, outValid4} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid: got %b expected 000", {outValid1, outValid2, outValid4});
    end
    vectors++;
    if ({outErr1, busy1, busy2, busy4} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_err_busy: got %b expected 0000", {outErr1, busy1, busy2, busy4});
    end
    vectors++;
    if (so1 !== 128'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_state_out: got %h expected 0", so1);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({inReady1, inReady2, inReady4} !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL reset_release_in_ready: got %b expected 111", {inReady1, inReady2, inReady4});
    end
    tick();
  endtask

  task automatic test_fips_round0();
    loadState(128'h3243f6a8885a308d313198a2e0370734);
    applyStimulus(4'd0);
    vectors++;
    if ({inReady1, busy1} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL fips_busy_flags: got in_ready/busy %b expected 01", {inReady1, busy1});
    end
    waitResults();
    vectors++;
    if (lat1 !== 5 || lat2 !== 3 || lat4 !== 2) begin
      miscompares++;
      $display("[TB] FAIL fips_latency: got %0d/%0d/%0d expected 5/3/2", lat1, lat2, lat4);
    end
    vectors++;
    if (so1 !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
      miscompares++;
      $display("[TB] FAIL fips_cpc1_state: got %h expected 193de3bea0f4e22b9ac68d2ae9f84808", so1);
    end
    vectors++;
    if (so2 !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
      miscompares++;
      $display("[TB] FAIL fips_cpc2_state: got %h expected 193de3bea0f4e22b9ac68d2ae9f84808", so2);
    end
    vectors++;
    if (so4 !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
      miscompares++;
      $display("[TB] FAIL fips_cpc4_state: got %h expected 193de3bea0f4e22b9ac68d2ae9f84808", so4);
    end
    vectors++;
    if ({outErr1, outErr2, outErr4, inReady1} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL fips_err_ready: got %b expected 0000", {outErr1, outErr2, outErr4, inReady1});
    end
    drain();
    vectors++;
    if ({inReady1, inReady2, inReady4, outValid1, busy1} !== 5'b11100) begin
      miscompares++;
      $display("[TB] FAIL fips_return_idle: got %b expected 11100", {inReady1, inReady2, inReady4, outValid1, busy1});
    end
  endtask

  task automatic test_last_round();
    loadState(128'h0);
    applyStimulus(4'd10);
    waitResults();
    vectors++;
    if (lat1 !== 5 || lat2 !== 3 || lat4 !== 2) begin
      miscompares++;
      $display("[TB] FAIL last_latency: got %0d/%0d/%0d expected 5/3/2", lat1, lat2, lat4);
    end
    vectors++;
    if (so1 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      miscompares++;
      $display("[TB] FAIL last_cpc1_state: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", so1);
    end
    vectors++;
    if (so2 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || so4 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      miscompares++;
      $display("[TB] FAIL last_cpc24_state: got %h / %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", so2, so4);
    end
    drain();
  endtask

  task automatic test_error_round();
    loadState(128'h3243f6a8885a308d313198a2e0370734);
    applyStimulus(4'd11);
    waitResults();
    vectors++;
    if (lat1 !== 1 || lat2 !== 1 || lat4 !== 1) begin
      miscompares++;
      $display("[TB] FAIL err_latency: got %0d/%0d/%0d expected 1/1/1", lat1, lat2, lat4);
    end
    vectors++;
    if ({outErr1, outErr2, outErr4} !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL err_flag: got %b expected 111", {outErr1, outErr2, outErr4});
    end
    vectors++;
    if (so1 !== 128'h3243f6a8885a308d313198a2e0370734 || so4 !== 128'h3243f6a8885a308d313198a2e0370734) begin
      miscompares++;
      $display("[TB] FAIL err_state_passthrough: got %h / %h expected 3243f6a8885a308d313198a2e0370734", so1, so4);
    end
    drain();
    vectors++;
    if ({outValid1, outErr1, inReady1} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL err_return_idle: got %b expected 001", {outValid1, outErr1, inReady1});
    end
  endtask

  task automatic test_back_pressure();
    loadState(128'h3243f6a8885a308d313198a2e0370734);
    applyStimulus(4'd0);
    waitResults();
    for (int n = 0; n < 7; n++) begin
      tick();
      vectors++;
      if (so1 !== 128'h193de3bea0f4e22b9ac68d2ae9f84808 || {outValid1, inReady1, busy1} !== 3'b101) begin
        miscompares++;
        $display("[TB] FAIL backpressure_hold_%0d: got %h valid/ready/busy %b expected 193de3bea0f4e22b9ac68d2ae9f84808 101",
                 n, so1, {outValid1, inReady1, busy1});
      end
    end
    drain();
    vectors++;
    if ({outValid1, inReady1, outValid4, inReady4} !== 4'b0101) begin
      miscompares++;
      $display("[TB] FAIL backpressure_release: got %b expected 0101", {outValid1, inReady1, outValid4, inReady4});
    end
  endtask

  task automatic test_midbusy_reset();
    loadState(128'h3243f6a8885a308d313198a2e0370734);
    applyStimulus(4'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if ({outValid1, outValid2, outValid4, busy1, inReady1} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL midreset_flags: got %b expected 00000", {outValid1, outValid2, outValid4, busy1, inReady1});
    end
    vectors++;
    if (so1 !== 128'h0 || so4 !== 128'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_state: got %h / %h expected 0", so1, so4);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (inReady1 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_in_ready: got %b expected 1", inReady1);
    end
    tick();
    applyStimulus(4'd10);
    waitResults();
    vectors++;
    if (lat1 !== 5 || so1 !== 128'he2570f0041b41504d00e946a56540b92) begin
      miscompares++;
      $display("[TB] FAIL midreset_next_block: got lat %0d state %h expected lat 5 state e2570f0041b41504d00e946a56540b92",
               lat1, so1);
    end
    drain();
  endtask

  // Apply round 0 to the FIPS output to recover the original input. The
  // input bus is scrambled and in_valid raised while the engines are busy;
  // neither may disturb the captured block.
  task automatic test_involution_ignore();
    loadState(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    applyStimulus(4'd0);
    loadState(128'hffffffffffffffffffffffffffffffff);
    in_round = 4'd5;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    waitResults();
    vectors++;
    if (so1 !== 128'h3243f6a8885a308d313198a2e0370734 || so2 !== 128'h3243f6a8885a308d313198a2e0370734) begin
      miscompares++;
      $display("[TB] FAIL involution_state: got %h / %h expected 3243f6a8885a308d313198a2e0370734", so1, so2);
    end
    vectors++;
    if (lat1 < 0 || lat2 < 0 || lat4 < 0) begin
      miscompares++;
      $display("[TB] FAIL involution_timeout: got %0d/%0d/%0d expected all to complete", lat1, lat2, lat4);
    end
    drain();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_round    = 4'd0;
    out_ready   = 1'b0;
    loadState(128'h0);
    loadKeys();

    test_reset();
    test_fips_round0();
    test_last_round();
    test_error_round();
    test_back_pressure();
    test_midbusy_reset();
    test_involution_ignore();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
